// File: rtl/regfile_mp.sv
// regfile_mp: parametrised register file with NUM_RD read ports, two
// prioritised byte-enabled write ports (port 1 wins on overlap), optional
// write-to-read bypass, optional registered reads, optional hardwired-zero
// entry 0, and a one-entry-per-cycle clear sweep.
module regfile_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD     = 2,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1,
  parameter int READ_REG   = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]  rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0]  rd_data,
  input  logic [1:0]                    wr_en,
  input  logic [2*ADDR_WIDTH-1:0]       wr_addr,
  input  logic [2*DATA_WIDTH-1:0]       wr_data,
  input  logic [2*(DATA_WIDTH/8)-1:0]   wr_be,
  output logic                          wr_ready,
  input  logic                          clear_req,
  output logic                          clear_busy
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH/8;

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;

  localparam addr_t ZERO_ADDR = {ADDR_WIDTH{1'b0}};
  localparam addr_t ONE_ADDR  = addr_t'(1'b1);
  localparam addr_t LAST_ADDR = {ADDR_WIDTH{1'b1}};
  localparam word_t ZERO_WORD = {DATA_WIDTH{1'b0}};

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // Replace the bytes of old_word selected by be with those of new_word.
  function automatic word_t merge_bytes(input word_t old_word, input word_t new_word,
                                        input logic [NB-1:0] be);
    word_t res;
    res = old_word;
    for (int b = 0; b < NB; b++) begin
      if (be[b]) begin
        res[b*8 +: 8] = new_word[b*8 +: 8];
      end else begin
        res[b*8 +: 8] = old_word[b*8 +: 8];
      end
    end
    return res;
  endfunction

  word_t           mem_r [DEPTH];
  state_t          state_r;
  state_t          state_next_s;
  addr_t           cnt_r;
  addr_t           cnt_next_s;
  logic            ready_s;

  addr_t           wr_addr0_s;
  addr_t           wr_addr1_s;
  logic            wr_ok0_s;
  logic            wr_ok1_s;
  word_t           wr_word0_s;
  word_t           wr_word1_s;
  word_t           base1_s;

  addr_t           rd_addr_s [NUM_RD];
  word_t           rd_word_s [NUM_RD];
  logic [NUM_RD*DATA_WIDTH-1:0] rd_comb_s;

  assign ready_s    = (state_r == ST_IDLE);
  assign clear_busy = (state_r == ST_CLEAR);
  assign wr_ready   = ready_s;

  // Clear sweep state and entry counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= ZERO_ADDR;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Clear sweep next-state: start on clear_req, leave after the last entry.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (clear_req) begin
          state_next_s = ST_CLEAR;
          cnt_next_s   = ZERO_ADDR;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        cnt_next_s = cnt_r + ONE_ADDR;
        if (cnt_r == LAST_ADDR) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_CLEAR;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        cnt_next_s   = ZERO_ADDR;
      end
    endcase
  end

  // Post-edge value of each written entry; port 1 is merged on top of port 0
  // when both target the same entry, so port 1 bytes win.
  always_comb begin
    wr_addr0_s = wr_addr[0 +: ADDR_WIDTH];
    wr_addr1_s = wr_addr[ADDR_WIDTH +: ADDR_WIDTH];
    wr_ok0_s   = wr_en[0] && ready_s && !((ZERO_REG != 0) && (wr_addr0_s == ZERO_ADDR));
    wr_ok1_s   = wr_en[1] && ready_s && !((ZERO_REG != 0) && (wr_addr1_s == ZERO_ADDR));
    wr_word0_s = merge_bytes(mem_r[wr_addr0_s], wr_data[0 +: DATA_WIDTH], wr_be[0 +: NB]);
    if (wr_ok0_s && (wr_addr0_s == wr_addr1_s)) begin
      base1_s = wr_word0_s;
    end else begin
      base1_s = mem_r[wr_addr1_s];
    end
    wr_word1_s = merge_bytes(base1_s, wr_data[DATA_WIDTH +: DATA_WIDTH], wr_be[NB +: NB]);
  end

  // Array update: the sweep owns the array while clearing, otherwise the
  // accepted writes land (port 1 assigned last so it wins a collision).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int e = 0; e < DEPTH; e++) begin
        mem_r[e] <= ZERO_WORD;
      end
    end else if (state_r == ST_CLEAR) begin
      mem_r[cnt_r] <= ZERO_WORD;
    end else begin
      if (wr_ok0_s) begin
        mem_r[wr_addr0_s] <= wr_word0_s;
      end
      if (wr_ok1_s) begin
        mem_r[wr_addr1_s] <= wr_word1_s;
      end
    end
  end

  // Read ports: array value, optionally overlaid with this cycle's writes.
  always_comb begin
    rd_comb_s = {(NUM_RD*DATA_WIDTH){1'b0}};
    for (int i = 0; i < NUM_RD; i++) begin
      rd_addr_s[i] = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      rd_word_s[i] = mem_r[rd_addr_s[i]];
      if ((BYPASS != 0) && wr_ok1_s && (wr_addr1_s == rd_addr_s[i])) begin
        rd_word_s[i] = wr_word1_s;
      end else if ((BYPASS != 0) && wr_ok0_s && (wr_addr0_s == rd_addr_s[i])) begin
        rd_word_s[i] = wr_word0_s;
      end else begin
        rd_word_s[i] = mem_r[rd_addr_s[i]];
      end
      if ((ZERO_REG != 0) && (rd_addr_s[i] == ZERO_ADDR)) begin
        rd_word_s[i] = ZERO_WORD;
      end else begin
        rd_word_s[i] = rd_word_s[i];
      end
      rd_comb_s[i*DATA_WIDTH +: DATA_WIDTH] = rd_word_s[i];
    end
  end

  generate
    if (READ_REG != 0) begin : g_rd_reg
      logic [NUM_RD*DATA_WIDTH-1:0] rd_data_r;

      // Registered read data: one cycle behind the presented address.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          rd_data_r <= {(NUM_RD*DATA_WIDTH){1'b0}};
        end else begin
          rd_data_r <= rd_comb_s;
        end
      end

      assign rd_data = rd_data_r;
    end else begin : g_rd_comb
      assign rd_data = rd_comb_s;
    end
  endgenerate

endmodule
